// File: rtl/sys_array_sched.sv
`default_nettype none
// ============================================================================
//  Module   : sys_array_sched
//  Purpose  : Operand scheduler for the 2x2 systolic array. Holds the A-row
//             and B-column vectors, streams them into the array's two edge
//             lanes (lane 1 skewed one accepted beat behind lane 0), then
//             waits for array completion and reports done/err.
//  Options  : SCHED_TIMEOUT_EN - enables the DRAIN watchdog (TO_CYC cycles).
//  Revision : 1.0 - initial release
// ============================================================================
module sys_array_sched #(
    parameter int N_MAX  = 8,
    parameter int DW     = 32,
    parameter int TO_CYC = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    // operand load port
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [1:0]                 ld_sel,
    input  logic [$clog2(N_MAX)-1:0]   ld_idx,
    input  logic [DW-1:0]              ld_dat,
    // job control
    input  logic                       start,
    input  logic [$clog2(N_MAX+1)-1:0] n_len,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    // lane 0: r1c1 row_in / col_in
    output logic [DW-1:0]              l0_a_dat,
    output logic [DW-1:0]              l0_b_dat,
    output logic                       l0_valid,
    input  logic                       l0_a_ready,
    input  logic                       l0_b_ready,
    // lane 1: r2c1 row_in / r1c2 col_in
    output logic [DW-1:0]              l1_a_dat,
    output logic [DW-1:0]              l1_b_dat,
    output logic                       l1_valid,
    input  logic                       l1_a_ready,
    input  logic                       l1_b_ready,
    // array status
    input  logic                       arr_comp_done,
    input  logic                       arr_error
);

    localparam int c_IW    = $clog2(N_MAX);
    localparam int c_CW    = $clog2(N_MAX + 1);
    localparam int c_DEPTH = 1 << c_IW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [c_CW-1:0] r_len, r_ctr0, r_ctr1, w_ctr0_nxt, w_ctr1_nxt;
    logic            r_l1_en, r_busy, r_done, r_err;
    logic            w_done_set, w_err_set, w_start_ok, w_timeout;
    logic            w_ld_fire, w_idx_ok, w_len_ok;
    logic            w_l0_valid, w_l1_valid, w_l0_fire, w_l1_fire;
    logic [31:0]     w_idx_ext;

    // Storage is sized to the full index range so every read index is in bounds.
    logic [DW-1:0] r_a1 [c_DEPTH];
    logic [DW-1:0] r_a2 [c_DEPTH];
    logic [DW-1:0] r_b1 [c_DEPTH];
    logic [DW-1:0] r_b2 [c_DEPTH];

    assign ld_ready  = (r_state == IDLE);
    assign w_ld_fire = ld_valid & ld_ready;
    assign w_idx_ext = 32'(ld_idx);
    assign w_idx_ok  = (w_idx_ext < 32'(N_MAX));
    assign w_len_ok  = (n_len != '0) && (32'(n_len) <= 32'(N_MAX));

    // Lane handshakes; the counter compare gates valid so counters saturate at len.
    assign w_l0_valid = (r_state == FEED) && (r_ctr0 != r_len);
    assign w_l1_valid = (r_state == FEED) && r_l1_en && (r_ctr1 != r_len);
    assign w_l0_fire  = w_l0_valid & l0_a_ready & l0_b_ready;
    assign w_l1_fire  = w_l1_valid & l1_a_ready & l1_b_ready;
    assign w_ctr0_nxt = r_ctr0 + {{(c_CW-1){1'b0}}, w_l0_fire};
    assign w_ctr1_nxt = r_ctr1 + {{(c_CW-1){1'b0}}, w_l1_fire};

    assign l0_valid = w_l0_valid;
    assign l1_valid = w_l1_valid;
    assign l0_a_dat = r_a1[r_ctr0[c_IW-1:0]];
    assign l0_b_dat = r_b1[r_ctr0[c_IW-1:0]];
    assign l1_a_dat = r_a2[r_ctr1[c_IW-1:0]];
    assign l1_b_dat = r_b2[r_ctr1[c_IW-1:0]];

    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

`ifdef SCHED_TIMEOUT_EN
    localparam int c_TW = $clog2(TO_CYC + 1);
    logic [c_TW-1:0] r_to_cnt;

    // DRAIN watchdog: counts cycles spent in DRAIN, restarts on every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_state == DRAIN) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    // Last allowed DRAIN cycle; FIN then lands exactly TO_CYC cycles after entry.
    assign w_timeout = (r_to_cnt == c_TW'(TO_CYC - 1));
`else
    // Watchdog compiled out; TO_CYC is positive so this tie-off is constant 0.
    localparam bit c_TO_NEVER = (TO_CYC < 0);
    assign w_timeout = c_TO_NEVER;
`endif

    // Operand write port; deliberately unreset so a job can be re-run after reset.
    always_ff @(posedge clk) begin
        if (w_ld_fire && w_idx_ok) begin
            case (ld_sel)
                2'd0:    r_a1[ld_idx] <= ld_dat;
                2'd1:    r_a2[ld_idx] <= ld_dat;
                2'd2:    r_b1[ld_idx] <= ld_dat;
                default: r_b2[ld_idx] <= ld_dat;
            endcase
        end
    end

    // Next-state and event decode.
    always_comb begin
        w_state_nxt = r_state;
        w_done_set  = 1'b0;
        w_err_set   = 1'b0;
        w_start_ok  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_len_ok) begin
                        w_start_ok  = 1'b1;
                        w_state_nxt = FEED;
                    end else begin
                        w_err_set  = 1'b1;
                        w_done_set = 1'b1;
                    end
                end
                if (w_ld_fire && !w_idx_ok) begin
                    w_err_set = 1'b1;
                end
            end
            FEED: begin
                if (arr_error) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = FIN;
                end else if ((w_ctr0_nxt == r_len) && (w_ctr1_nxt == r_len)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (arr_error) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = FIN;
                end else if (arr_comp_done) begin
                    w_state_nxt = FIN;
                end else if (w_timeout) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = FIN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // FIN is only ever entered from FEED/DRAIN, so this marks the FIN cycle.
        if (w_state_nxt == FIN) begin
            w_done_set = 1'b1;
        end
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_ctr0  <= '0;
            r_ctr1  <= '0;
            r_l1_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == FEED) || (w_state_nxt == DRAIN);
            r_done  <= w_done_set;
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_start_ok) begin
                r_err <= 1'b0;
            end
            if (w_start_ok) begin
                r_len   <= n_len;
                r_ctr0  <= '0;
                r_ctr1  <= '0;
                r_l1_en <= 1'b0;
            end else if (r_state == FEED) begin
                r_ctr0 <= w_ctr0_nxt;
                r_ctr1 <= w_ctr1_nxt;
                if (w_l0_fire) begin
                    r_l1_en <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sys_array_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sys_array_sched
//  Purpose  : Self-checking bench for sys_array_sched. A behavioural 2x2
//             dot-product array captures every lane beat; job results are
//             predicted from the bench's own operand copy at start and
//             compared when the job's done pulse arrives.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sys_array_sched;

    localparam int N_MAX  = 8;
    localparam int DW     = 32;
    localparam int TO_CYC = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid, ld_ready;
    logic [1:0]    ld_sel;
    logic [2:0]    ld_idx;
    logic [DW-1:0] ld_dat;
    logic          start;
    logic [3:0]    n_len;
    logic          busy, done, err;
    logic [DW-1:0] l0_a_dat, l0_b_dat, l1_a_dat, l1_b_dat;
    logic          l0_valid, l1_valid;
    logic          l0_a_ready, l0_b_ready, l1_a_ready, l1_b_ready;
    logic          arr_comp_done, arr_error;

    always #5 clk = ~clk;

    sys_array_sched #(.N_MAX(N_MAX), .DW(DW), .TO_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
        .ld_idx(ld_idx), .ld_dat(ld_dat),
        .start(start), .n_len(n_len), .busy(busy), .done(done), .err(err),
        .l0_a_dat(l0_a_dat), .l0_b_dat(l0_b_dat), .l0_valid(l0_valid),
        .l0_a_ready(l0_a_ready), .l0_b_ready(l0_b_ready),
        .l1_a_dat(l1_a_dat), .l1_b_dat(l1_b_dat), .l1_valid(l1_valid),
        .l1_a_ready(l1_a_ready), .l1_b_ready(l1_b_ready),
        .arr_comp_done(arr_comp_done), .arr_error(arr_error)
    );

    // ---------------- bench model state ----------------
    logic [DW-1:0] m_a1 [N_MAX];
    logic [DW-1:0] m_a2 [N_MAX];
    logic [DW-1:0] m_b1 [N_MAX];
    logic [DW-1:0] m_b2 [N_MAX];

    typedef struct {
        bit    err;
        longint r11, r12, r21, r22;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int n_len;
        bit stall;
        bit exp_err;
        int exp_fires;
        int exp_dly;   // cycles from start sample to done pulse
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    longint got_r11, got_r12, got_r21, got_r22;

    // ---------------- monitor / array model ----------------
    int            cyc = 0;
    int            t_start, first0, first1, done_cyc, cur_len;
    int            f0 = 0, f1 = 0, done_cnt = 0, held0, hold_bad, any_valid;
    logic [DW-1:0] fa1 [N_MAX];
    logic [DW-1:0] fb1 [N_MAX];
    logic [DW-1:0] fa2 [N_MAX];
    logic [DW-1:0] fb2 [N_MAX];
    bit            prev_hold0 = 1'b0;
    logic [DW-1:0] prev_a0, prev_b0;
    bit            cd_en = 1'b1;

    // The modelled array reports completion once it has absorbed len beats per lane.
    assign arr_comp_done = cd_en && (cur_len != 0) && (f0 == cur_len) && (f1 == cur_len);

    // Observe lane traffic mid-cycle; a fire seen here happens at the next rising edge.
    always @(negedge clk) begin
        bit w_f0, w_f1;
        cyc = cyc + 1;
        if (!rst && start && ld_ready) begin
            t_start = cyc; f0 = 0; f1 = 0; done_cnt = 0; held0 = 0; hold_bad = 0;
            any_valid = 0; first0 = -1; first1 = -1; done_cyc = -1;
            cur_len = int'(n_len); prev_hold0 = 1'b0;
        end
        w_f0 = l0_valid && l0_a_ready && l0_b_ready;
        w_f1 = l1_valid && l1_a_ready && l1_b_ready;
        if (l0_valid || l1_valid) any_valid = 1;
        if (prev_hold0 && ((l0_a_dat != prev_a0) || (l0_b_dat != prev_b0))) hold_bad = hold_bad + 1;
        if (l0_valid && !w_f0) held0 = held0 + 1;
        prev_hold0 = l0_valid && !w_f0;
        prev_a0 = l0_a_dat;
        prev_b0 = l0_b_dat;
        if (w_f0 && f0 < N_MAX) begin
            if (f0 == 0) first0 = cyc;
            fa1[f0] = l0_a_dat; fb1[f0] = l0_b_dat; f0 = f0 + 1;
        end
        if (w_f1 && f1 < N_MAX) begin
            if (f1 == 0) first1 = cyc;
            fa2[f1] = l1_a_dat; fb2[f1] = l1_b_dat; f1 = f1 + 1;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int sel, input int idx, input logic [DW-1:0] dat);
        ld_valid = 1'b1; ld_sel = 2'(sel); ld_idx = 3'(idx); ld_dat = dat;
        case (sel)
            0: m_a1[idx] = dat;
            1: m_a2[idx] = dat;
            2: m_b1[idx] = dat;
            default: m_b2[idx] = dat;
        endcase
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic run_job(input string tag, input vec_t v);
        exp_t e, g;
        int   m;
        e.err = v.exp_err; e.r11 = 0; e.r12 = 0; e.r21 = 0; e.r22 = 0;
        for (int k = 0; k < v.exp_fires; k++) begin
            e.r11 += longint'(m_a1[k]) * longint'(m_b1[k]);
            e.r12 += longint'(m_a1[k]) * longint'(m_b2[k]);
            e.r21 += longint'(m_a2[k]) * longint'(m_b1[k]);
            e.r22 += longint'(m_a2[k]) * longint'(m_b2[k]);
        end
        sb.push_back(e);

        n_len = 4'(v.n_len); start = 1'b1;
        tick();
        start = 1'b0;
        if (v.exp_fires > 0) begin
            check({tag, "_busy_t1"}, busy, 1);
            check({tag, "_l0valid_t1"}, l0_valid, 1);
            check({tag, "_ldready_t1"}, ld_ready, 0);
        end else begin
            check({tag, "_busy_illegal"}, busy, 0);
        end
        if (v.stall) begin
            tick(); l0_b_ready = 1'b0;
            tick();
            tick(); l0_b_ready = 1'b1;
        end
        for (int i = 0; i < 300 && done_cnt == 0; i++) tick();
        check({tag, "_done_seen"}, (done_cnt != 0), 1);
        tick(); tick();

        e = sb.pop_front();
        g.r11 = 0; g.r12 = 0; g.r21 = 0; g.r22 = 0;
        m = (f0 < f1) ? f0 : f1;
        for (int k = 0; k < f0; k++) g.r11 += longint'(fa1[k]) * longint'(fb1[k]);
        for (int k = 0; k < f1; k++) g.r22 += longint'(fa2[k]) * longint'(fb2[k]);
        for (int k = 0; k < m; k++) begin
            g.r12 += longint'(fa1[k]) * longint'(fb2[k]);
            g.r21 += longint'(fa2[k]) * longint'(fb1[k]);
        end
        got_r11 = g.r11; got_r12 = g.r12; got_r21 = g.r21; got_r22 = g.r22;

        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_done_dly"}, done_cyc - t_start, v.exp_dly);
        check({tag, "_err"}, err, e.err);
        check({tag, "_fires0"}, f0, v.exp_fires);
        check({tag, "_fires1"}, f1, v.exp_fires);
        check({tag, "_r1c1"}, g.r11, e.r11);
        check({tag, "_r1c2"}, g.r12, e.r12);
        check({tag, "_r2c1"}, g.r21, e.r21);
        check({tag, "_r2c2"}, g.r22, e.r22);
        check({tag, "_idle_ldready"}, ld_ready, 1);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_hold_stable"}, hold_bad, 0);
        check({tag, "_stall_cycles"}, held0, v.stall ? 2 : 0);
        if (v.exp_fires == 0) check({tag, "_no_valid"}, any_valid, 0);
        if (v.exp_fires > 0 && !v.stall) begin
            check({tag, "_first0_lat"}, first0 - t_start, 1);
            check({tag, "_skew"}, first1 - first0, 1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vec_t vecs[6];
        vec_t vj;
        vecs[0] = '{n_len: 3,         stall: 0, exp_err: 0, exp_fires: 3,     exp_dly: 6};
        vecs[1] = '{n_len: 0,         stall: 0, exp_err: 1, exp_fires: 0,     exp_dly: 1};
        vecs[2] = '{n_len: N_MAX + 1, stall: 0, exp_err: 1, exp_fires: 0,     exp_dly: 1};
        vecs[3] = '{n_len: 3,         stall: 1, exp_err: 0, exp_fires: 3,     exp_dly: 7};
        vecs[4] = '{n_len: 1,         stall: 0, exp_err: 0, exp_fires: 1,     exp_dly: 4};
        vecs[5] = '{n_len: N_MAX,     stall: 0, exp_err: 0, exp_fires: N_MAX, exp_dly: N_MAX + 3};

        rst = 1'b1; ld_valid = 1'b0; ld_sel = '0; ld_idx = '0; ld_dat = '0;
        start = 1'b0; n_len = '0; arr_error = 1'b0;
        l0_a_ready = 1'b1; l0_b_ready = 1'b1; l1_a_ready = 1'b1; l1_b_ready = 1'b1;
        tick(); tick();
        check("rst_ldready", ld_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_l0valid", l0_valid, 0);
        check("rst_l1valid", l1_valid, 0);
        rst = 1'b0;
        tick();

        // A row1 = B col1 = {1,2,3,...}, A row2 = B col2 = {4,5,6,...}
        for (int i = 0; i < N_MAX; i++) begin
            load(0, i, DW'(i + 1));
            load(1, i, DW'(i + 4));
            load(2, i, DW'(i + 1));
            load(3, i, DW'(i + 4));
        end

        for (int i = 0; i < 6; i++) begin
            run_job($sformatf("vec%0d", i), vecs[i]);
        end

        // Array error on lane 0's second beat aborts the job.
        n_len = 4'd3; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        tick(); arr_error = 1'b1;
        tick(); arr_error = 1'b0;
        check("abort_l0valid", l0_valid, 0);
        check("abort_l1valid", l1_valid, 0);
        check("abort_done", done, 1);
        check("abort_err", err, 1);
        check("abort_busy", busy, 0);
        tick();
        check("abort_done_fall", done, 0);
        vj = '{n_len: 2, stall: 0, exp_err: 0, exp_fires: 2, exp_dly: 5};
        run_job("after_abort", vj);

        // Asynchronous reset in the middle of FEED, then re-run without reloading.
        n_len = 4'd3; start = 1'b1;
        tick(); start = 1'b0;
        tick(); rst = 1'b1;
        #1;
        check("midrst_ldready", ld_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_err", err, 0);
        check("midrst_l0valid", l0_valid, 0);
        check("midrst_l1valid", l1_valid, 0);
        check("midrst_l0a", l0_a_dat, m_a1[0]);
        check("midrst_l0b", l0_b_dat, m_b1[0]);
        check("midrst_l1a", l1_a_dat, m_a2[0]);
        check("midrst_l1b", l1_b_dat, m_b2[0]);
        tick(); tick(); rst = 1'b0;
        tick(); tick(); tick();
        check("midrst_no_done", done_cnt, 0);
        vj = '{n_len: 3, stall: 0, exp_err: 0, exp_fires: 3, exp_dly: 6};
        run_job("rerun", vj);
        check("rerun_r1c1_14", got_r11, 14);
        check("rerun_r1c2_32", got_r12, 32);
        check("rerun_r2c1_32", got_r21, 32);
        check("rerun_r2c2_77", got_r22, 77);

`ifdef SCHED_TIMEOUT_EN
        // Array never completes: watchdog ends the job TO_CYC cycles after DRAIN entry.
        cd_en = 1'b0;
        vj = '{n_len: 2, stall: 0, exp_err: 1, exp_fires: 2, exp_dly: 2 + 2 + TO_CYC};
        run_job("timeout", vj);
        cd_en = 1'b1;
        vj = '{n_len: 2, stall: 0, exp_err: 0, exp_fires: 2, exp_dly: 5};
        run_job("after_timeout", vj);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire

// File: doc/sys_array_sched.md
# sys_array_sched

Job scheduler for the 2x2 DSP systolic array. It holds the A-row and B-column operand vectors in local registers, written by a load port. On `start` it streams them into the array's four edge inputs over valid/ready, with row 2 / column 2 skewed one accepted beat behind row 1 / column 1. It then waits for the array's completion flags and reports `done`/`err`. It replaces the hard-wired reset-loaded shift registers that feed the array today.

## Interface
- `N_MAX`, 8: maximum inner dimension n; operand storage depth per vector.
- `DW`, 32: operand width (single_float).
- `TO_CYC`, 64: drain watchdog limit in cycles (only with `SCHED_TIMEOUT_EN`).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ld_valid` in 1 / `ld_ready` out 1: operand write handshake.
- `ld_sel` in 2: target vector; 0 = A row1, 1 = A row2, 2 = B col1, 3 = B col2.
- `ld_idx` in $clog2(N_MAX): element index.
- `ld_dat` in DW: element value.
- `start` in 1: launch job.
- `n_len` in $clog2(N_MAX+1): job inner dimension, sampled on `start`.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle end-of-job pulse.
- `err` out 1: sticky job error flag.
- `l0_a_dat`, `l0_b_dat` out DW: lane 0 data to r1c1 row_in and col_in.
- `l0_valid` out 1: drives both r1c1 row_in_valid and col_in_valid.
- `l0_a_ready`, `l0_b_ready` in 1: r1c1 row_in_ready and col_in_ready.
- `l1_a_dat`, `l1_b_dat`, `l1_valid`, `l1_a_ready`, `l1_b_ready`: same as lane 0, connected to r2c1 row_in and r1c2 col_in.
- `arr_comp_done` in 1: AND of all PE comp_done.
- `arr_error` in 1: OR of all PE error bits.

## Operation
- FSM states: IDLE, FEED, DRAIN, FIN.
- IDLE:
  - `ld_ready`=1. A load beat writes `ld_dat` into vector `ld_sel` at element `ld_idx`.
  - `ld_idx` ≥ N_MAX: the beat is accepted but dropped, and `err` is set.
  - `start` with 1 ≤ `n_len` ≤ N_MAX: latch `len`, clear `err`, clear both lane counters, go to FEED.
  - `start` with `n_len`=0 or `n_len` > N_MAX: set `err`, pulse `done`, stay in IDLE.
- FEED:
  - Lane 0 presents element `ctr0` of A row1 and B col1. `l0_valid` = (`ctr0` != `len`).
  - Lane 0 fires when `l0_valid & l0_a_ready & l0_b_ready`. Each fire increments `ctr0`.
  - Lane 1 is enabled the cycle after lane 0's first fire (flag `l1_en`), then behaves the same with `ctr1`.
  - Each vector is consumed index 0 first.
  - When both counters equal `len`, go to DRAIN.
- DRAIN: wait for `arr_comp_done`=1, then go to FIN.
- FIN: pulse `done`, then go to IDLE.
- `arr_error` seen in FEED or DRAIN: set `err`, drop both valids, go to FIN (abort).
- `ld_ready`=0 outside IDLE. `start` outside IDLE is ignored.
- Operand registers are not cleared on reset or by `start`. Contents persist across jobs, so a job can be re-run without reloading.
- Counter widths are $clog2(N_MAX+1). Counters never wrap; they saturate at `len` because valid is gated.

## Timing
- Reset values:
  - state IDLE, `ld_ready`=1, `busy`=0, `done`=0, `err`=0.
  - `l0_valid`=`l1_valid`=0, counters 0, `l1_en`=0.
  - `*_dat` outputs show element 0 of their vectors.
- `start` sampled in cycle T: `busy`=1 and `l0_valid`=1 from T+1.
- With no backpressure:
  - Lane 0 fires at T+1..T+len.
  - Lane 1 fires at T+2..T+len+1.
  - DRAIN is entered at T+len+2.
- `done` is high for exactly one cycle, in the FIN cycle. `busy` falls in that same cycle; `busy` is registered and is 1 only in FEED/DRAIN.
- Data outputs are combinational from storage indexed by the counter. They are stable while valid is high and not fired.
- Simultaneous fire of lane 0 and lane 1 in the same cycle is legal.
- Reset asserted mid-job returns the FSM to IDLE immediately. No `done` pulse is produced.

## Configuration
- `SCHED_TIMEOUT_EN` defined:
  - A DRAIN cycle counter runs from entry to DRAIN.
  - If `arr_comp_done` is not seen within `TO_CYC` cycles, set `err` and go to FIN.
- Not defined: DRAIN waits indefinitely, and `TO_CYC` is unused.

## Test plan
- Basic job:
  - Stimulus: load A row1={1,2,3}, A row2={4,5,6}, B col1={1,2,3}, B col2={4,5,6}; `n_len`=3; start; real 2x2 array attached.
  - Required: `done` once, `err`=0; r1c1=14.0, r1c2=32.0, r2c1=32.0, r2c2=77.0.
  - Required with no stalls: lane 1's first fire is exactly 1 cycle after lane 0's first fire.
- Backpressure:
  - Stimulus: same job; drop `l0_b_ready` for 2 cycles mid-stream.
  - Required: `l0_a_dat`/`l0_b_dat` held stable through the stall; `ctr0` does not advance; exactly 3 fires per lane.
- Illegal length: `start` with `n_len`=0, then with `n_len`=N_MAX+1 -> `err`=1, one `done` pulse each, `l0_valid` never asserted.
- Array error abort: `arr_error`=1 on lane 0's 2nd fire -> both valids low next cycle, `done` pulse, `err`=1, next legal `start` clears `err`.
- Reset mid-FEED: assert `rst` after 1 fire -> all outputs at reset values immediately; a rerun with `n_len`=3 yields the same results as the basic job without reloading operands.
- Timeout (`SCHED_TIMEOUT_EN` defined): hold `arr_comp_done`=0 -> `err`=1 and `done` pulse exactly `TO_CYC` cycles after DRAIN entry.
